// File: rtl/typecs_rx.sv
// Packet receiver/parser for the typec byte link: frames SYNC/PID/DLEN/CMD/CRC packets and
// holds decoded btype plus command fields for the consumer under an fs/fd handshake.
module typecs_rx #(
  parameter bit         CRC_EN = 1'b1,
  parameter logic [7:0] SYNC_B = 8'h01
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_com_rxd,
  output logic       o_fs,
  input  logic       i_fd,
  output logic [3:0] o_btype,
  output logic [3:0] o_didx,
  output logic [3:0] o_freq,
  output logic [3:0] o_ddidx,
  output logic       o_err
);

  typedef enum logic [3:0] {
    StIdle,
    StWait,
    StRpid,
    StRlen0,
    StRlen1,
    StRcmd,
    StRcrc,
    StDone,
    StErr
  } state_e;

  state_e     r_state, w_state_nxt;
  logic [7:0] r_cmd, w_cmd_nxt;
  logic [3:0] r_btype, w_btype_nxt;
  logic [3:0] r_didx, w_didx_nxt;
  logic [3:0] r_freq, w_freq_nxt;
  logic [3:0] r_ddidx, w_ddidx_nxt;
  logic       r_fs, w_fs_nxt;
  logic       r_err, w_err_nxt;
  logic       w_crc_ok;

  // USB CRC5: x^5+x^2+1, init all-ones, LSB first, complemented result.
  function automatic logic [4:0] crc5(input logic [7:0] data);
    logic [4:0] crc;
    logic       fb;
    crc = 5'h1F;
    for (int i = 0; i < 8; i++) begin
      fb  = crc[4] ^ data[i];
      crc = {crc[3:0], 1'b0};
      if (fb) crc = crc ^ 5'h05;
    end
    return ~crc;
  endfunction

  assign w_crc_ok = !CRC_EN || (i_com_rxd == {3'b000, crc5(r_cmd)});

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_btype_nxt = r_btype;
    w_didx_nxt  = r_didx;
    w_freq_nxt  = r_freq;
    w_ddidx_nxt = r_ddidx;
    case (r_state)
      StIdle: w_state_nxt = StWait;
      StWait: if (i_com_rxd == SYNC_B) w_state_nxt = StRpid;
      StRpid: begin
        case (i_com_rxd)
          8'h2D: begin w_btype_nxt = 4'd1; w_state_nxt = StDone; end
          8'hA5: begin w_btype_nxt = 4'd2; w_state_nxt = StDone; end
          8'hE1: begin w_btype_nxt = 4'd3; w_state_nxt = StDone; end
          8'h1E: w_state_nxt = StRlen0;
          default: w_state_nxt = StErr;
        endcase
      end
      StRlen0: w_state_nxt = (i_com_rxd == 8'h00) ? StRlen1 : StErr;
      StRlen1: w_state_nxt = (i_com_rxd == 8'h01) ? StRcmd : StErr;
      StRcmd: begin
        w_cmd_nxt   = i_com_rxd;
        w_state_nxt = StRcrc;
      end
      StRcrc: begin
        w_state_nxt = StErr;
        if (w_crc_ok) begin
          case (r_cmd[7:4])
            4'h9: begin w_btype_nxt = 4'd5; w_didx_nxt  = r_cmd[3:0]; w_state_nxt = StDone; end
            4'h5: begin w_btype_nxt = 4'd6; w_freq_nxt  = r_cmd[3:0]; w_state_nxt = StDone; end
            4'h1: begin w_btype_nxt = 4'd7; w_ddidx_nxt = r_cmd[3:0]; w_state_nxt = StDone; end
            default: w_state_nxt = StErr;
          endcase
        end
      end
      // Incoming bytes are dropped while the consumer still holds the previous packet.
      StDone: if (i_fd) w_state_nxt = StWait;
      StErr:  w_state_nxt = StWait;
      default: w_state_nxt = StWait;
    endcase
    w_fs_nxt  = (w_state_nxt == StDone);
    w_err_nxt = (w_state_nxt == StErr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cmd   <= 8'h00;
      r_btype <= 4'h0;
      r_didx  <= 4'h0;
      r_freq  <= 4'h0;
      r_ddidx <= 4'h0;
      r_fs    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_btype <= w_btype_nxt;
      r_didx  <= w_didx_nxt;
      r_freq  <= w_freq_nxt;
      r_ddidx <= w_ddidx_nxt;
      r_fs    <= w_fs_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_fs    = r_fs;
  assign o_err   = r_err;
  assign o_btype = r_btype;
  assign o_didx  = r_didx;
  assign o_freq  = r_freq;
  assign o_ddidx = r_ddidx;

endmodule
